// File: rtl/rssi_meter.sv
// Per-ADC signal-level meter: leaky-integrator RSSI and clip rate, plus a
// software-triggered windowed sum/peak/clip-count measurement with done pulse.
module rssi_meter #(
  parameter int WIDTH     = 12,
  parameter int SHIFT     = 10,
  parameter int OUT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       adc,
  input  logic                   adc_stb,
  output logic [OUT_WIDTH-1:0]   rssi,
  output logic [OUT_WIDTH-1:0]   over_count,
  input  logic                   start,
  input  logic [15:0]            win_len,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH+14:0]      win_sum,
  output logic [WIDTH-2:0]       win_peak,
  output logic [15:0]            win_clips
);

  localparam int ACC_W = OUT_WIDTH + SHIFT;
  localparam int SUM_W = WIDTH + 15;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic               clear;
  logic [WIDTH-2:0]   mag;
  logic               clip;

  logic [ACC_W-1:0]   rssi_acc, over_acc;
  logic [ACC_W-1:0]   rssi_acc_next, over_acc_next;

  logic [15:0]        len, cnt;
  logic [SUM_W-1:0]   run_sum, sum_next;
  logic [WIDTH-2:0]   run_peak, peak_next;
  logic [15:0]        run_clips, clips_next;
  logic               win_start, win_accept, win_finish;

  // Disabling the block is indistinguishable from holding it in reset.
  assign clear = reset | ~enable;

  // One's-complement magnitude: cheap, and symmetric so full-scale negative
  // reads the same as full-scale positive.
  assign mag  = adc[WIDTH-1] ? ~adc[WIDTH-2:0] : adc[WIDTH-2:0];
  assign clip = (adc == {1'b0, {(WIDTH-1){1'b1}}}) ||
                (adc == {1'b1, {(WIDTH-1){1'b0}}});

  // Steady state of a constant input v is v*2^SHIFT, so the accumulators never
  // overflow; any intermediate wrap of the add cancels in the subtract.
  assign rssi_acc_next = rssi_acc + ACC_W'(mag) - ACC_W'(rssi_acc[ACC_W-1:SHIFT]);
  assign over_acc_next = over_acc + (clip ? ACC_W'({OUT_WIDTH{1'b1}}) : '0)
                       - ACC_W'(over_acc[ACC_W-1:SHIFT]);

  assign rssi       = rssi_acc[ACC_W-1:SHIFT];
  assign over_count = over_acc[ACC_W-1:SHIFT];

  assign sum_next   = run_sum + SUM_W'(mag);
  assign peak_next  = (mag > run_peak) ? mag : run_peak;
  assign clips_next = (clip && (run_clips != 16'hFFFF)) ? run_clips + 16'd1 : run_clips;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    win_start  = 1'b0;
    win_accept = 1'b0;
    win_finish = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          win_start  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (adc_stb) begin
          win_accept = 1'b1;
          if (cnt + 16'd1 == len) begin
            win_finish = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rssi_acc  <= '0;
      over_acc  <= '0;
      len       <= '0;
      cnt       <= '0;
      run_sum   <= '0;
      run_peak  <= '0;
      run_clips <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_sum   <= '0;
      win_peak  <= '0;
      win_clips <= '0;
    end else begin
      busy <= (state_next == RUN);
      done <= win_finish;

      if (adc_stb) begin
        rssi_acc <= rssi_acc_next;
        over_acc <= over_acc_next;
      end

      // A start cycle's own sample is never counted: accumulation begins in RUN.
      if (win_start) begin
        len       <= (win_len == 16'd0) ? 16'd1 : win_len;
        cnt       <= '0;
        run_sum   <= '0;
        run_peak  <= '0;
        run_clips <= '0;
      end else if (win_accept) begin
        cnt       <= cnt + 16'd1;
        run_sum   <= sum_next;
        run_peak  <= peak_next;
        run_clips <= clips_next;
      end

      if (win_finish) begin
        win_sum   <= sum_next;
        win_peak  <= peak_next;
        win_clips <= clips_next;
      end
    end
  end

endmodule

// File: tb/tb_rssi_meter.sv
// Directed-vector bench for rssi_meter: window results are checked by a
// done-driven scoreboard, level outputs by direct checks against hand values.
module tb_rssi_meter;

  localparam int WIDTH     = 12;
  localparam int SHIFT     = 10;
  localparam int OUT_WIDTH = 16;

  logic                 clock = 1'b0;
  logic                 reset, enable, adc_stb, start;
  logic [WIDTH-1:0]     adc;
  logic [15:0]          win_len;
  logic [OUT_WIDTH-1:0] rssi, over_count;
  logic                 busy, done;
  logic [WIDTH+14:0]    win_sum;
  logic [WIDTH-2:0]     win_peak;
  logic [15:0]          win_clips;

  typedef struct {
    longint sum;
    longint peak;
    longint clips;
  } win_t;

  win_t exp_q[$];
  win_t mon_exp;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  rssi_meter #(.WIDTH(WIDTH), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .adc        (adc),
    .adc_stb    (adc_stb),
    .rssi       (rssi),
    .over_count (over_count),
    .start      (start),
    .win_len    (win_len),
    .busy       (busy),
    .done       (done),
    .win_sum    (win_sum),
    .win_peak   (win_peak),
    .win_clips  (win_clips)
  );

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic void expect_win(input longint s, input longint p, input longint c);
    exp_q.push_back('{s, p, c});
  endfunction

  // Scoreboard monitor: every done pulse consumes one expected window result.
  always @(negedge clock) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("win_sum",   win_sum,   mon_exp.sum,   mon_exp.sum);
        check("win_peak",  win_peak,  mon_exp.peak,  mon_exp.peak);
        check("win_clips", win_clips, mon_exp.clips, mon_exp.clips);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sample(input logic [WIDTH-1:0] v);
    adc     = v;
    adc_stb = 1'b1;
    tick();
    adc_stb = 1'b0;
  endtask

  task automatic start_win(input logic [15:0] n);
    win_len = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       busy,       0, 0);
    check({tag, "_done"},       done,       0, 0);
    check({tag, "_rssi"},       rssi,       0, 0);
    check({tag, "_over_count"}, over_count, 0, 0);
    check({tag, "_win_sum"},    win_sum,    0, 0);
    check({tag, "_win_peak"},   win_peak,   0, 0);
    check({tag, "_win_clips"},  win_clips,  0, 0);
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    adc     = '0;
    adc_stb = 1'b0;
    start   = 1'b0;
    win_len = '0;
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(2);

    // Basic window: 10 + |-20|(=19) + 5 + 2047, gaps between strobes.
    expect_win(2081, 2047, 1);
    start_win(16'd4);
    check("win4_busy", busy, 1, 1);
    sample(12'd10);
    idle(2);
    sample(12'hFEC);
    sample(12'd5);
    idle(3);
    sample(12'h7FF);
    check("win4_done", done, 1, 1);
    tick();
    check("win4_busy_after", busy, 0, 0);
    check("win4_done_pulse", done, 0, 0);

    // Zero length behaves as one sample; full-scale negative is a clip.
    expect_win(2047, 2047, 1);
    start_win(16'd0);
    sample(12'h800);
    check("len0_done", done, 1, 1);
    idle(2);

    // start during RUN must neither restart nor shorten the window.
    expect_win(6, 3, 0);
    start_win(16'd3);
    sample(12'd1);
    start_win(16'd1);
    sample(12'd2);
    check("restart_no_done", done, 0, 0);
    sample(12'd3);
    check("restart_done", done, 1, 1);
    idle(2);

    // Back-to-back: start in the done cycle; that cycle's sample is excluded.
    expect_win(17, 9, 0);
    expect_win(7, 4, 0);
    start_win(16'd2);
    sample(12'd9);
    sample(12'd8);
    check("b2b_done1", done, 1, 1);
    win_len = 16'd2;
    start   = 1'b1;
    adc     = 12'd100;
    adc_stb = 1'b1;
    tick();
    start   = 1'b0;
    adc_stb = 1'b0;
    check("b2b_busy", busy, 1, 1);
    sample(12'd3);
    sample(12'd4);
    check("b2b_done2", done, 1, 1);
    idle(2);

    // Reset mid-window clears everything and never publishes the window.
    start_win(16'd100);
    for (int i = 0; i < 50; i++) sample(12'h7FF);
    check("pre_reset_rssi_nonzero", rssi, 1, 65535);
    reset = 1'b1;
    tick();
    check_all_zero("midrun_reset");
    reset = 1'b0;
    idle(2);

    // enable low aborts a window the same way.
    start_win(16'd5);
    sample(12'd7);
    enable = 1'b0;
    tick();
    check("enable_low_busy", busy, 0, 0);
    check("enable_low_win_sum", win_sum, 0, 0);
    enable = 1'b1;
    idle(2);

    // Longest window, every sample clipped; also drives the clip-rate integrator.
    expect_win(64'd2047 * 64'd65535, 2047, 65535);
    start_win(16'hFFFF);
    adc     = 12'h7FF;
    adc_stb = 1'b1;
    idle(65534);
    check("long_not_early", done, 0, 0);
    tick();
    check("long_done", done, 1, 1);
    adc_stb = 1'b0;
    check("clip_rate_full", over_count, 65530, 65535);
    idle(2);

    // Half the samples clipped: clip rate settles near half scale.
    for (int i = 0; i < 10000; i++) begin
      adc     = i[0] ? 12'h000 : 12'h800;
      adc_stb = 1'b1;
      tick();
    end
    adc_stb = 1'b0;
    check("clip_rate_half", over_count, 32767 - 64, 32767 + 64);

    // Constant 100: rssi converges, no clips.
    adc     = 12'd100;
    adc_stb = 1'b1;
    idle(13000);
    adc_stb = 1'b0;
    check("rssi_converge", rssi, 99, 100);
    check("rssi_no_clip", over_count, 0, 0);

    // Without strobes the integrators hold even with a loud input present.
    adc = 12'h7FF;
    idle(1000);
    check("rssi_hold", rssi, 99, 100);
    check("over_hold", over_count, 0, 0);

    idle(4);
    check("scoreboard_drained", exp_q.size(), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
